// File: rtl/pn_spreader_core_if.sv
// Sample stream bundle for pn_spreader_core: input samples in, spread chips out.
// The core connects through the slave modport and the data source/sink through master.
interface pn_spreader_core_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] i_tdata;
  logic               i_tlast;
  logic               i_tvalid;
  logic               i_tready;
  logic [2*WIDTH-1:0] o_tdata;
  logic               o_tlast;
  logic               o_tvalid;
  logic               o_tready;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/pn_spreader_core.sv
// Direct-sequence spreader: each I/Q sample is repeated SF times, every chip
// multiplied by +/-1 from a Fibonacci LFSR, with shadowed per-packet configuration.
module pn_spreader_core #(
  parameter int WIDTH     = 16,
  parameter int MAX_ORDER = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  input  logic                 cfg_stb,
  input  logic [MAX_ORDER-1:0] cfg_poly,
  input  logic [MAX_ORDER-1:0] cfg_seed,
  input  logic [4:0]           cfg_order,
  input  logic [CNT_W-1:0]     cfg_sf,
  input  logic [CNT_W-1:0]     cfg_len,
  input  logic                 cfg_mode,
  pn_spreader_core_if.slave    strm,
  output logic                 busy,
  output logic                 cfg_err
);

  typedef enum logic {IDLE, SPREAD} state_t;
  state_t state_q, state_d;

  logic [MAX_ORDER-1:0] sh_poly_q, sh_poly_d, sh_seed_q, sh_seed_d;
  logic [MAX_ORDER-1:0] act_poly_q, act_poly_d, act_seed_q, act_seed_d;
  logic [MAX_ORDER-1:0] lfsr_q, lfsr_d;
  logic [4:0]           sh_order_q, sh_order_d, act_order_q, act_order_d;
  logic [CNT_W-1:0]     sh_sf_q, sh_sf_d, sh_len_q, sh_len_d;
  logic [CNT_W-1:0]     act_sf_q, act_sf_d, act_len_q, act_len_d;
  logic [CNT_W-1:0]     chip_cnt_q, chip_cnt_d, pn_cnt_q, pn_cnt_d;
  logic                 sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic                 sh_valid_q, sh_valid_d, pend_q, pend_d;
  logic                 in_pkt_q, in_pkt_d, last_q, last_d;
  logic [2*WIDTH-1:0]   sample_q, sample_d;

  logic last_chip, o_hs, accept;

  function automatic logic [MAX_ORDER-1:0] order_mask(input logic [4:0] ord);
    logic [MAX_ORDER-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_ORDER; i++) m[i] = (i < 32'(ord));
    return m;
  endfunction

  function automatic logic [MAX_ORDER-1:0] lfsr_next(input logic [MAX_ORDER-1:0] st,
                                                     input logic [MAX_ORDER-1:0] poly,
                                                     input logic [4:0]           ord);
    logic                 fb;
    logic [MAX_ORDER-1:0] nx;
    fb = ^(st & poly);
    nx = st >> 1;
    for (int unsigned i = 0; i < MAX_ORDER; i++) begin
      if (i + 1 == 32'(ord)) nx[i] = fb;
    end
    return nx & order_mask(ord);
  endfunction

  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] most_neg;
    most_neg = '0;
    most_neg[WIDTH-1] = 1'b1;
    return (x == most_neg) ? ~most_neg : (~x + 1'b1);
  endfunction

  always_comb begin
    cfg_err   = !sh_valid_q || (sh_order_q == '0) || (int'(sh_order_q) > MAX_ORDER);
    last_chip = (chip_cnt_q == act_sf_q - 1'b1);
    o_hs      = (state_q == SPREAD) && strm.o_tready;
    accept    = strm.i_tvalid && strm.i_tready;
  end

  assign strm.i_tready = !cfg_err && ((state_q == IDLE) || (last_chip && o_hs));
  assign strm.o_tvalid = (state_q == SPREAD);
  assign strm.o_tlast  = (state_q == SPREAD) && last_chip && last_q;
  assign strm.o_tdata  = lfsr_q[0] ? sample_q
                       : {sat_neg(sample_q[2*WIDTH-1:WIDTH]), sat_neg(sample_q[WIDTH-1:0])};
  assign busy          = (state_q == SPREAD);

  always_comb begin
    state_d     = state_q;
    sh_poly_d   = sh_poly_q;
    sh_seed_d   = sh_seed_q;
    sh_order_d  = sh_order_q;
    sh_sf_d     = sh_sf_q;
    sh_len_d    = sh_len_q;
    sh_mode_d   = sh_mode_q;
    sh_valid_d  = sh_valid_q;
    pend_d      = pend_q;
    act_poly_d  = act_poly_q;
    act_seed_d  = act_seed_q;
    act_order_d = act_order_q;
    act_sf_d    = act_sf_q;
    act_len_d   = act_len_q;
    act_mode_d  = act_mode_q;
    lfsr_d      = lfsr_q;
    chip_cnt_d  = chip_cnt_q;
    pn_cnt_d    = pn_cnt_q;
    in_pkt_d    = in_pkt_q;
    last_d      = last_q;
    sample_d    = sample_q;

    if (cfg_stb) begin
      sh_poly_d  = cfg_poly;
      sh_seed_d  = cfg_seed;
      sh_order_d = cfg_order;
      sh_sf_d    = cfg_sf;
      sh_len_d   = cfg_len;
      sh_mode_d  = cfg_mode;
      sh_valid_d = 1'b1;
      pend_d     = 1'b1;
    end

    if (o_hs) begin
      if ((act_len_q != '0) && (pn_cnt_q == act_len_q - 1'b1)) begin
        lfsr_d   = act_seed_q & order_mask(act_order_q);
        pn_cnt_d = '0;
      end else begin
        lfsr_d   = lfsr_next(lfsr_q, act_poly_q, act_order_q);
        pn_cnt_d = pn_cnt_q + 1'b1;
      end
      if (last_chip) begin
        chip_cnt_d = '0;
        state_d    = IDLE;
      end else begin
        chip_cnt_d = chip_cnt_q + 1'b1;
      end
    end

    // A packet-start accept can coincide with the final chip beat; the
    // reload below then takes precedence over the advance computed above.
    if (accept) begin
      sample_d   = strm.i_tdata;
      last_d     = strm.i_tlast;
      chip_cnt_d = '0;
      state_d    = SPREAD;
      in_pkt_d   = !strm.i_tlast;
      if (!in_pkt_q) begin
        if (pend_q) begin
          act_poly_d  = sh_poly_q;
          act_seed_d  = sh_seed_q;
          act_order_d = sh_order_q;
          act_sf_d    = (sh_sf_q == '0) ? CNT_W'(1) : sh_sf_q;
          act_len_d   = sh_len_q;
          act_mode_d  = sh_mode_q;
          lfsr_d      = sh_seed_q & order_mask(sh_order_q);
          pn_cnt_d    = '0;
          pend_d      = cfg_stb;
        end else if (!act_mode_q) begin
          lfsr_d   = act_seed_q & order_mask(act_order_q);
          pn_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      sh_poly_q   <= '0;
      sh_seed_q   <= '0;
      sh_order_q  <= '0;
      sh_sf_q     <= '0;
      sh_len_q    <= '0;
      sh_mode_q   <= 1'b0;
      sh_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      act_poly_q  <= '0;
      act_seed_q  <= '0;
      act_order_q <= '0;
      act_sf_q    <= '0;
      act_len_q   <= '0;
      act_mode_q  <= 1'b0;
      lfsr_q      <= '0;
      chip_cnt_q  <= '0;
      pn_cnt_q    <= '0;
      in_pkt_q    <= 1'b0;
      last_q      <= 1'b0;
      sample_q    <= '0;
    end else begin
      sh_poly_q   <= sh_poly_d;
      sh_seed_q   <= sh_seed_d;
      sh_order_q  <= sh_order_d;
      sh_sf_q     <= sh_sf_d;
      sh_len_q    <= sh_len_d;
      sh_mode_q   <= sh_mode_d;
      sh_valid_q  <= sh_valid_d;
      pend_q      <= pend_d;
      act_poly_q  <= act_poly_d;
      act_seed_q  <= act_seed_d;
      act_order_q <= act_order_d;
      act_sf_q    <= act_sf_d;
      act_len_q   <= act_len_d;
      act_mode_q  <= act_mode_d;
      lfsr_q      <= lfsr_d;
      chip_cnt_q  <= chip_cnt_d;
      pn_cnt_q    <= pn_cnt_d;
      in_pkt_q    <= in_pkt_d;
      last_q      <= last_d;
      sample_q    <= sample_d;
    end
  end

endmodule

// File: tb/tb_pn_spreader_core.sv
// Directed bench for pn_spreader_core: hand-computed chip sequences, framing,
// saturation, stall stability, config shadowing and mid-packet reset.
module tb_pn_spreader_core;
    localparam int W  = 16;
    localparam int MO = 16;
    localparam int CW = 16;

    localparam logic [31:0] P100 = 32'h0064_0064;
    localparam logic [31:0] N100 = 32'hFF9C_FF9C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cfg_stb;
    logic [MO-1:0] cfg_poly, cfg_seed;
    logic [4:0]    cfg_order;
    logic [CW-1:0] cfg_sf, cfg_len;
    logic          cfg_mode;
    logic          busy, cfg_err;

    pn_spreader_core_if #(.WIDTH(W)) bus ();

    pn_spreader_core #(.WIDTH(W), .MAX_ORDER(MO), .CNT_W(CW)) dut (
        .ce_clk   (clk),
        .ce_rst   (rst),
        .cfg_stb  (cfg_stb),
        .cfg_poly (cfg_poly),
        .cfg_seed (cfg_seed),
        .cfg_order(cfg_order),
        .cfg_sf   (cfg_sf),
        .cfg_len  (cfg_len),
        .cfg_mode (cfg_mode),
        .strm     (bus),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] q_d[$];
    bit          q_l[$];
    bit          q_r[$];
    int          q_c[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: records handshaken beats and verifies held values across stalls.
    initial begin
        bit          stalled;
        logic [31:0] hold_d;
        bit          hold_l;
        stalled = 1'b0;
        hold_d  = '0;
        hold_l  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stalled && !rst) begin
                check("stall_valid", 64'(bus.o_tvalid), 64'd1);
                check("stall_data",  64'(bus.o_tdata),  64'(hold_d));
                check("stall_last",  64'(bus.o_tlast),  64'(hold_l));
            end
            stalled = bus.o_tvalid && !bus.o_tready && !rst;
            hold_d  = bus.o_tdata;
            hold_l  = bus.o_tlast;
            if (bus.o_tvalid && bus.o_tready) begin
                q_d.push_back(bus.o_tdata);
                q_l.push_back(bus.o_tlast);
                q_r.push_back(bus.i_tready);
                q_c.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_d.delete();
        q_l.delete();
        q_r.delete();
        q_c.delete();
    endtask

    task automatic configure(input logic [MO-1:0] poly, input logic [MO-1:0] seed,
                             input logic [4:0] order, input logic [CW-1:0] sf,
                             input logic [CW-1:0] len, input logic mode);
        cfg_poly  = poly;
        cfg_seed  = seed;
        cfg_order = order;
        cfg_sf    = sf;
        cfg_len   = len;
        cfg_mode  = mode;
        cfg_stb   = 1'b1;
        tick();
        cfg_stb   = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input bit lst);
        bit done;
        done = 1'b0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = d;
        bus.i_tlast  = lst;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = bus.i_tready;
            tick();
        end
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || bus.o_tvalid) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic cmp_beats(input string tag, input int n, input logic [31:0] chips,
                             input logic [31:0] lasts, input logic [31:0] pos,
                             input logic [31:0] neg);
        check({tag, "_count"}, 64'(q_d.size()), 64'(n));
        for (int k = 0; k < n && k < q_d.size(); k++) begin
            check($sformatf("%s_data%0d", tag, k), 64'(q_d[k]), 64'(chips[k] ? pos : neg));
            check($sformatf("%s_last%0d", tag, k), 64'(q_l[k]), 64'(lasts[k]));
        end
    endtask

    initial begin
        cfg_stb      = 1'b0;
        cfg_poly     = '0;
        cfg_seed     = '0;
        cfg_order    = '0;
        cfg_sf       = '0;
        cfg_len      = '0;
        cfg_mode     = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.o_tready = 1'b1;

        #3;
        check("rst_tvalid", 64'(bus.o_tvalid), 64'd0);
        check("rst_tlast",  64'(bus.o_tlast),  64'd0);
        check("rst_tdata",  64'(bus.o_tdata),  64'd0);
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_cfgerr", 64'(cfg_err),      64'd1);
        check("rst_tready", 64'(bus.i_tready), 64'd0);
        #20 rst = 1'b0;
        tick();
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = P100;
        #1;
        check("nocfg_cfgerr", 64'(cfg_err),      64'd1);
        check("nocfg_tready", 64'(bus.i_tready), 64'd0);
        tick();
        check("nocfg_busy",   64'(busy),         64'd0);
        bus.i_tvalid = 1'b0;

        // Order 3, poly 011, seed 001, sf 1, free-run: period-7 chips 1,0,0,1,0,1,1.
        configure(16'h3, 16'h1, 5'd3, 16'd1, 16'd0, 1'b1);
        check("cfg_ok_err", 64'(cfg_err), 64'd0);
        clear_q();
        for (int i = 0; i < 14; i++) send(P100, i == 13);
        drain();
        cmp_beats("seq7", 14, 32'b11010011101001, 32'h2000, P100, N100);

        // SF 4, two samples: eight back-to-back beats, tlast on the eighth only.
        configure(16'h3, 16'h1, 5'd3, 16'd4, 16'd0, 1'b1);
        clear_q();
        send(P100, 1'b0);
        send(P100, 1'b1);
        drain();
        cmp_beats("sf4", 8, 32'b11101001, 32'h80, P100, N100);
        if (q_c.size() == 8) begin
            check("sf4_consecutive", 64'(q_c[7] - q_c[0]), 64'd7);
            check("sf4_rdy_beat4",   64'(q_r[3]), 64'd1);
            check("sf4_rdy_beat3",   64'(q_r[2]), 64'd0);
        end

        // Seed 100: chips 0,0,1,0,1; I=-32768 saturates on negation; o_tready toggles.
        configure(16'h3, 16'h4, 5'd3, 16'd5, 16'd0, 1'b1);
        clear_q();
        fork
            send(32'h8000_0005, 1'b1);
            begin
                for (int i = 0; i < 16; i++) begin
                    bus.o_tready = !bus.o_tready;
                    tick();
                end
            end
        join
        bus.o_tready = 1'b1;
        drain();
        cmp_beats("sat", 5, 32'b10100, 32'h10, 32'h8000_0005, 32'h7FFF_FFFB);

        // PN length 3 reloads the seed every third chip.
        configure(16'h3, 16'h1, 5'd3, 16'd1, 16'd3, 1'b1);
        clear_q();
        for (int i = 0; i < 6; i++) send(P100, i == 5);
        drain();
        cmp_beats("len3", 6, 32'b001001, 32'h20, P100, N100);

        // Mode 0: every packet restarts from the seed.
        configure(16'h3, 16'h1, 5'd3, 16'd1, 16'd0, 1'b0);
        clear_q();
        send(P100, 1'b0);
        send(P100, 1'b1);
        send(P100, 1'b0);
        send(P100, 1'b1);
        drain();
        cmp_beats("mode0", 4, 32'b0101, 32'b1010, P100, N100);

        // Order 0 invalidates the config and blocks input.
        configure(16'h3, 16'h1, 5'd0, 16'd1, 16'd0, 1'b1);
        check("ord0_cfgerr", 64'(cfg_err), 64'd1);
        bus.i_tvalid = 1'b1;
        #1;
        check("ord0_tready", 64'(bus.i_tready), 64'd0);
        tick();
        check("ord0_busy", 64'(busy), 64'd0);
        bus.i_tvalid = 1'b0;

        // Mid-packet strobe with sf 1 leaves the sf-2 packet untouched.
        configure(16'h3, 16'h1, 5'd3, 16'd2, 16'd0, 1'b1);
        clear_q();
        fork
            begin
                send(P100, 1'b0);
                send(P100, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                configure(16'h3, 16'h1, 5'd3, 16'd1, 16'd0, 1'b1);
            end
        join
        send(P100, 1'b1);
        drain();
        cmp_beats("midcfg", 5, 32'b11001, 32'b11000, P100, N100);

        // Asynchronous reset in the middle of a sample.
        configure(16'h3, 16'h1, 5'd3, 16'd4, 16'd0, 1'b1);
        clear_q();
        fork
            send(P100, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #3 rst = 1'b1;
                #1;
                check("arst_tvalid", 64'(bus.o_tvalid), 64'd0);
                check("arst_busy",   64'(busy),         64'd0);
                check("arst_cfgerr", 64'(cfg_err),      64'd1);
                #3 rst = 1'b0;
            end
        join
        clear_q();
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = P100;
        bus.i_tlast  = 1'b1;
        repeat (10) tick();
        check("postrst_beats",  64'(q_d.size()),  64'd0);
        check("postrst_busy",   64'(busy),        64'd0);
        check("postrst_tready", 64'(bus.i_tready), 64'd0);
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
        configure(16'h3, 16'h1, 5'd3, 16'd4, 16'd0, 1'b1);
        send(P100, 1'b1);
        drain();
        cmp_beats("postrst", 4, 32'b1001, 32'b1000, P100, N100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/pn_spreader_core.md
PN_SPREADER_CORE -- requirements
Module: pn_spreader_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per I/Q component (sample = 2*WIDTH bits, I in upper half).
REQ-002 SHALL have parameter MAX_ORDER, default 16, meaning maximum LFSR order (state width).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of spreading-factor and PN-length fields.
REQ-004 SHALL have ports: ce_clk  in  1  sole clock; ce_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: cfg_stb  in  1  config strobe; cfg_poly, cfg_seed  in  MAX_ORDER  tap mask, seed; cfg_order  in  5  LFSR order; cfg_sf  in  CNT_W  chips per sample; cfg_len  in  CNT_W  PN period (0 = free-run); cfg_mode  in  1  0 = reseed every packet, 1 = continuous.
REQ-006 SHALL have ports: i_tdata  in  2*WIDTH; i_tlast, i_tvalid  in  1; i_tready  out  1.
REQ-007 SHALL have ports: o_tdata  out  2*WIDTH; o_tlast, o_tvalid  out  1; o_tready  in  1; busy  out  1; cfg_err  out  1.

Function
REQ-008 SHALL latch all cfg_* into shadow registers on cfg_stb, in any state, and set a pending-apply flag.
REQ-009 SHALL set cfg_err = 1 while the shadow config is invalid: cfg_order 0 or > MAX_ORDER, or no cfg_stb since reset; i_tready SHALL be 0 while cfg_err = 1.
REQ-010 SHALL treat cfg_sf = 0 as 1.
REQ-011 SHALL apply the shadow config (active SF, length, mode; LFSR loaded with cfg_seed masked to order bits; PN counter cleared) only when accepting the first sample of a packet.
REQ-012 SHALL additionally reload the LFSR with seed and clear the PN counter at every packet start when active mode = 0.
REQ-013 SHALL implement a Fibonacci LFSR: chip bit = state[0]; fb = XOR-reduce(state AND poly); next = state >> 1 with bit (order-1) := fb; bits >= order forced to 0.
REQ-014 SHALL advance the LFSR and the PN counter only on an output handshake (o_tvalid and o_tready).
REQ-015 SHALL, when cfg_len != 0, reload the LFSR with seed and clear the PN counter on the handshake of chip number cfg_len of the period, instead of advancing.
REQ-016 SHALL use a two-state FSM, IDLE and SPREAD: IDLE -> SPREAD on input accept; SPREAD -> IDLE on last-chip handshake with no new sample accepted in the same cycle.
REQ-017 SHALL drive i_tready = !cfg_err and (IDLE, or SPREAD with last chip and o_tready); this gives back-to-back samples at SF cycles per sample.
REQ-018 SHALL hold the accepted sample and i_tlast in registers; o_tvalid SHALL be 1 in SPREAD starting the cycle after accept.
REQ-019 SHALL drive o_tdata = sample when the chip bit is 1, else the per-component two's-complement negation, saturating -2^(WIDTH-1) to 2^(WIDTH-1)-1.
REQ-020 SHALL assert o_tlast only on the last chip (chip index SF-1) of a sample latched with i_tlast = 1.
REQ-021 SHALL hold o_tdata, o_tlast and o_tvalid stable while o_tvalid = 1 and o_tready = 0.
REQ-022 SHALL drive busy = 1 in SPREAD.
REQ-023 SHALL leave a cfg_stb arriving mid-packet without effect on the current packet.

Reset
REQ-024 SHALL, on ce_rst asserted at any time, asynchronously force: FSM IDLE; o_tvalid, o_tlast, busy 0; o_tdata 0; i_tready 0; cfg_err 1; LFSR, counters and shadow registers 0; pending flag 0.
REQ-025 SHALL discard any in-flight sample and chips on reset; the first handshake after release requires a new cfg_stb.

Verification
REQ-026 Order 3, poly 3'b011, seed 3'b001, sf 1, len 0, mode 1, 7 samples I=Q=100, o_tready=1 -> chips +,-,-,+,-,+,+ (100,-100,-100,100,-100,100,100), then sequence repeats.
REQ-027 sf 4, 2-sample packet with tlast on sample 2, o_tready=1 -> 8 output beats in 8 consecutive cycles; i_tready high on beat 4; o_tlast only on beat 8.
REQ-028 Sample I=-32768, Q=5, chip bit 0 -> o_tdata I=32767, Q=-5; with o_tready toggled 1/0, output is stable while stalled and no chip is skipped or duplicated.
REQ-029 Setup of REQ-026 with len 3, mode 1, 6 samples -> chips 1,0,0,1,0,0; mode 0 with two 2-sample packets -> each packet starts with chip 1,0.
REQ-030 cfg_stb with order 0 -> cfg_err=1, i_tready=0; cfg_stb mid-packet with new sf -> current packet keeps old sf, next packet uses new sf.
REQ-031 ce_rst pulsed in SPREAD mid-sample -> o_tvalid 0 immediately, busy 0, cfg_err 1; no output until new cfg_stb and new sample.
